// File: rtl/mem_port_ctrl.sv
// ---------------------------------------------------------------------------
// mem_port_ctrl: clears one memory port after reset, then serves in-order
// read/write requests through a 2-entry read-response buffer.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_ctrl #(
  parameter int WIDTH = 8,
  parameter int ADDR  = 3,
  parameter int DEPTH = 2**ADDR
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic             i_req_we,
  input  logic [ADDR-1:0]  i_req_addr,
  input  logic [WIDTH-1:0] i_req_din,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_dout,
  output logic             o_mem_en,
  output logic             o_mem_we,
  output logic [ADDR-1:0]  o_mem_addr,
  output logic [WIDTH-1:0] o_mem_din,
  input  logic [WIDTH-1:0] i_mem_dout,
  output logic             o_init_done
);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t           r_state;
  logic [ADDR-1:0]  r_init_addr;
  logic             r_rd_pend;
  logic [WIDTH-1:0] r_buf [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;

  logic [2:0]       w_occ;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;

  // Ready looks only at registered occupancy so no input can reach it.
  assign w_occ       = {1'b0, r_count} + {2'b00, r_rd_pend};
  assign o_req_ready = (r_state == ST_RUN) && (w_occ < 3'd2);
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_push      = r_rd_pend;
  assign w_pop       = o_rsp_valid && i_rsp_ready;

  assign o_init_done = (r_state == ST_RUN);
  assign o_rsp_valid = (r_count != 2'd0);
  assign o_rsp_dout  = r_buf[r_rptr];

  // Memory port is held idle while reset is applied, even before the edge.
  always_comb begin
    o_mem_en   = 1'b0;
    o_mem_we   = 1'b0;
    o_mem_addr = '0;
    o_mem_din  = '0;
    if (!i_rst) begin
      if (r_state == ST_INIT) begin
        o_mem_en   = 1'b1;
        o_mem_we   = 1'b1;
        o_mem_addr = r_init_addr;
      end else if (w_accept) begin
        o_mem_en   = 1'b1;
        o_mem_we   = i_req_we;
        o_mem_addr = i_req_addr;
        o_mem_din  = i_req_din;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_INIT;
      r_init_addr <= '0;
      r_rd_pend   <= 1'b0;
      r_buf[0]    <= '0;
      r_buf[1]    <= '0;
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_count     <= 2'd0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_init_addr <= r_init_addr + 1'b1;
          if (r_init_addr == ADDR'(DEPTH - 1)) r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase

      r_rd_pend <= w_accept && !i_req_we;

      if (w_push) begin
        r_buf[r_wptr] <= i_mem_dout;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire
